// File: rtl/parity_mem_pkg.sv
// Shared limits and the parity helper for the parity-protected memory.
// par() takes a zero-extended word: the zero padding leaves the XOR reduction unchanged.
package parity_mem_pkg;

   localparam int MAX_READ_LAT = 8;
   localparam int MAX_DATA_W   = 64;

   function automatic logic par(input logic [MAX_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_mem_if.sv
// Request/response/error-counter bundle of the parity memory.
// master drives requests and response ready; slave is the memory side.
interface parity_mem_if
   import parity_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              inj_err;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_parity_err;
   logic              rsp_unwritten;
   logic              err_clr;
   logic [CNT_W-1:0]  err_count;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, inj_err, rsp_ready, err_clr,
      input  req_ready, rsp_valid, rsp_data, rsp_parity_err, rsp_unwritten, err_count
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, inj_err, rsp_ready, err_clr,
      output req_ready, rsp_valid, rsp_data, rsp_parity_err, rsp_unwritten, err_count
   );

endinterface

// File: rtl/parity_mem_pipe.sv
// One enabled read-pipeline register; d/q MSB is the stage valid bit (the only reset bit).
// Latency 1 cycle; holds its contents whenever en is low.
module parity_mem_pipe #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic         vld;
   logic [W-2:0] dat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= 1'b0;
      end else if (en) begin
         vld <= d[W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         dat <= d[W-2:0];
      end
   end

   assign q = {vld, dat};

endmodule

// File: rtl/parity_mem_ctrl.sv
// Parity-protected RAM with written-flag tracking and a READ_LAT-deep stall-all read pipe.
// A stalled response freezes every stage and deasserts req_ready; writes produce no response.
module parity_mem_ctrl
   import parity_mem_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int READ_LAT   = 2,
   parameter int PARITY_ODD = 0,
   parameter int CNT_W      = 8
) (
   input logic            clk,
   input logic            rst_n,
   parity_mem_if.slave    bus
);

   localparam int   DEPTH = 1 << ADDR_W;
   localparam logic ODD   = (PARITY_ODD != 0);

   typedef struct packed {
      logic              valid;
      logic              written;
      logic              parity;
      logic [DATA_W-1:0] data;
   } rd_stage_t;

   localparam int SW = $bits(rd_stage_t);

   logic [DATA_W:0]  mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic [DATA_W:0]  rd_word;
   rd_stage_t        stage_in;
   rd_stage_t        pipe_q [READ_LAT];
   rd_stage_t        last;
   logic             stall;
   logic             advance;
   logic             wr_fire;
   logic             rd_fire;
   logic             par_bad;
   logic             err_hs;
   logic [CNT_W-1:0] cnt;

   assign last    = pipe_q[READ_LAT-1];
   assign stall   = last.valid && !bus.rsp_ready;
   assign advance = !stall;

   assign bus.req_ready = rst_n && !stall;
   assign wr_fire       = bus.req_valid && bus.req_ready && bus.req_write;
   assign rd_fire       = bus.req_valid && bus.req_ready && !bus.req_write;

   // Flop array with a combinational read so a write at edge t is visible to a read accepted at t+1.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[bus.req_addr] <= {par(MAX_DATA_W'(bus.req_wdata), ODD) ^ bus.inj_err, bus.req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         written <= '0;
      end else if (wr_fire) begin
         written[bus.req_addr] <= 1'b1;
      end
   end

   assign rd_word = mem[bus.req_addr];

   always_comb begin
      stage_in         = '0;
      stage_in.valid   = rd_fire;
      stage_in.written = written[bus.req_addr];
      stage_in.parity  = rd_word[DATA_W];
      stage_in.data    = rd_word[DATA_W-1:0];
   end

   for (genvar i = 0; i < READ_LAT; i++) begin : g_stage
      if (i == 0) begin : g_first
         parity_mem_pipe #(.W(SW)) u_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .d     (stage_in),
            .q     (pipe_q[i])
         );
      end else begin : g_next
         parity_mem_pipe #(.W(SW)) u_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .d     (pipe_q[i-1]),
            .q     (pipe_q[i])
         );
      end
   end

   // Unwritten words hold arbitrary contents, so they never report a parity error.
   assign par_bad = last.written && (par(MAX_DATA_W'(last.data), ODD) != last.parity);

   assign bus.rsp_valid      = last.valid;
   assign bus.rsp_data       = (last.valid && last.written) ? last.data : '0;
   assign bus.rsp_parity_err = last.valid && par_bad;
   assign bus.rsp_unwritten  = last.valid && !last.written;

   assign err_hs = bus.rsp_valid && bus.rsp_ready && bus.rsp_parity_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.err_clr) begin
         cnt <= '0;
      end else if (err_hs && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.err_count = cnt;

endmodule
